// File: rtl/arith_pkg.sv
// arith_pkg: shared arithmetic definitions used by pipe_sub and the adder blocks.
//   DATA_W  - datapath width of the arithmetic blocks (32 bits)
//   stage_t - one pipeline stage register: data word, borrow/carry flag, valid flag
package arith_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              borrow;
    logic              valid;
  } stage_t;

endpackage

// File: rtl/sub_slice.sv
// sub_slice: W-bit ripple subtractor slice, d = a - b - bin.
// Computed as a + ~b + ~bin so that the borrow out is the inverted carry out.
// Ports:
//   a, b  - minuend / subtrahend slice (W bits)
//   bin   - borrow in from the less significant slice
//   d     - difference slice (W bits)
//   bout  - borrow out (1 when a < b + bin)
module sub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    d    = '0;
    c[0] = ~bin;
    for (int i = 0; i < W; i++) begin
      d[i]   = a[i] ^ ~b[i] ^ c[i];
      c[i+1] = (a[i] & ~b[i]) | (a[i] & c[i]) | (~b[i] & c[i]);
    end
    bout = ~c[W];
  end

endmodule

// File: rtl/pipe_sub.sv
// pipe_sub: two-stage pipelined 32-bit subtractor, D = A - B mod 2^32.
// Stage 1 registers the low difference [SPLIT-1:0], its borrow, and both
// candidate high differences (borrow-in 0 and 1). Stage 2 picks the high
// candidate with the stage-1 low borrow and registers D / Bout.
// Handshake: a transfer happens on a rising CLK edge when valid and ready are
// both 1 on that side; valid never depends on ready, In_Ready is a
// combinational function of pipeline occupancy and Out_Ready only.
// Ports:
//   CLK, RST            - clock, asynchronous active-high reset
//   A, B, In_Valid      - operands and their valid
//   In_Ready            - operands accepted this cycle
//   D, Bout, Out_Valid  - registered difference, borrow out (A<B unsigned), valid
//   Out_Ready           - consumer accepts D/Bout
//   Ovf                 - signed overflow, present only with PIPE_SUB_OVF_EN
// Optional feature macro: PIPE_SUB_OVF_EN
module pipe_sub
  import arith_pkg::*;
#(
  parameter int SPLIT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [DATA_W-1:0] D,
  output logic              Bout,
  output logic              Out_Valid,
`ifdef PIPE_SUB_OVF_EN
  output logic              Ovf,
`endif
  input  logic              Out_Ready
);

  localparam int LW = SPLIT;
  localparam int HW = DATA_W - SPLIT;

  // Combinational half differences
  logic [LW-1:0] lo_d;
  logic          lo_b;
  logic [HW-1:0] hi_d0, hi_d1;
  logic          hi_b0, hi_b1;

  sub_slice #(.W(LW)) u_lo (
    .a(A[LW-1:0]), .b(B[LW-1:0]), .bin(1'b0), .d(lo_d), .bout(lo_b)
  );
  sub_slice #(.W(HW)) u_hi0 (
    .a(A[DATA_W-1:LW]), .b(B[DATA_W-1:LW]), .bin(1'b0), .d(hi_d0), .bout(hi_b0)
  );
  sub_slice #(.W(HW)) u_hi1 (
    .a(A[DATA_W-1:LW]), .b(B[DATA_W-1:LW]), .bin(1'b1), .d(hi_d1), .bout(hi_b1)
  );

  // Stage 1 registers
  logic          s1_valid;
  logic [LW-1:0] s1_lo;
  logic          s1_lo_b;
  logic [HW-1:0] s1_hi0, s1_hi1;
  logic          s1_hb0, s1_hb1;
`ifdef PIPE_SUB_OVF_EN
  logic          s1_a_msb, s1_b_msb;
  logic          ovf_r;
`endif

  // Stage 2 register
  stage_t s2;

  logic          s2_en;
  logic          in_fire;
  logic [HW-1:0] sel_hi;
  logic          sel_b;

  assign s2_en    = s1_valid & (~s2.valid | Out_Ready);
  assign In_Ready = ~s1_valid | s2_en;
  assign in_fire  = In_Valid & In_Ready;

  // The low borrow decides which precomputed high half is the real one.
  assign sel_hi = s1_lo_b ? s1_hi1 : s1_hi0;
  assign sel_b  = s1_lo_b ? s1_hb1 : s1_hb0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_lo_b  <= 1'b0;
      s1_hi0   <= '0;
      s1_hi1   <= '0;
      s1_hb0   <= 1'b0;
      s1_hb1   <= 1'b0;
`ifdef PIPE_SUB_OVF_EN
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
`endif
    end else begin
      // A new load wins over draining into stage 2, keeping s1_valid at 1.
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_lo    <= lo_d;
        s1_lo_b  <= lo_b;
        s1_hi0   <= hi_d0;
        s1_hi1   <= hi_d1;
        s1_hb0   <= hi_b0;
        s1_hb1   <= hi_b1;
`ifdef PIPE_SUB_OVF_EN
        s1_a_msb <= A[DATA_W-1];
        s1_b_msb <= B[DATA_W-1];
`endif
      end else if (s2_en) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2 <= '0;
`ifdef PIPE_SUB_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else if (s2_en) begin
      s2.data   <= {sel_hi, s1_lo};
      s2.borrow <= sel_b;
      s2.valid  <= 1'b1;
`ifdef PIPE_SUB_OVF_EN
      ovf_r <= (s1_a_msb ^ s1_b_msb) & (sel_hi[HW-1] ^ s1_a_msb);
`endif
    end else if (Out_Ready) begin
      s2.valid <= 1'b0;
    end
  end

  assign D         = s2.data;
  assign Bout      = s2.borrow;
  assign Out_Valid = s2.valid;
`ifdef PIPE_SUB_OVF_EN
  assign Ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_sub.sv
// tb_pipe_sub: self-checking bench for pipe_sub (default SPLIT).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected results are queued at input acceptance and popped by
// the monitor on each output transfer.
module tb_pipe_sub;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] A, B;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] D;
  logic        Bout;
  logic        Out_Valid;
  logic        Out_Ready;
`ifdef PIPE_SUB_OVF_EN
  logic        Ovf;
`endif

  pipe_sub dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .D(D), .Bout(Bout), .Out_Valid(Out_Valid),
`ifdef PIPE_SUB_OVF_EN
    .Ovf(Ovf),
`endif
    .Out_Ready(Out_Ready)
  );

  // Clock / cycle counter
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard state: {ovf, bout, d}, expected output cycle, latency-check flag
  logic [33:0] exp_q[$];
  int          cyc_q[$];
  bit          chk_q[$];
  bit          lat_chk;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Driver: present one pair, wait (bounded) for acceptance, queue expectation.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic eb, input logic eo);
    bit done;
    int n;
    done = 0;
    n = 0;
    A = a;
    B = b;
    In_Valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge CLK);
      if (In_Ready) begin
        exp_q.push_back({eo, eb, ed});
        cyc_q.push_back(cyc + 2);
        chk_q.push_back(lat_chk);
        done = 1;
      end
      @(posedge CLK);
      #1;
      n++;
    end
    In_Valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: pair 0x%0h - 0x%0h not accepted in 50 cycles", a, b);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    cyc_q.delete();
    chk_q.delete();
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (!RST && Out_Valid && Out_Ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: D=0x%0h Bout=%0b with empty queue", D, Bout);
      end else begin
        logic [33:0] e;
        int          ec;
        bit          lc;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        lc = chk_q.pop_front();
        check("result_d", 64'(D), 64'(e[31:0]));
        check("result_bout", 64'(Bout), 64'(e[32]));
`ifdef PIPE_SUB_OVF_EN
        check("result_ovf", 64'(Ovf), 64'(e[33]));
`endif
        if (lc) check("latency_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // Directed vectors: a, b, expected d, bout, ovf
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t dir_v[8] = '{
    '{32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0},
    '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0},
    '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1},
    '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1},
    '{32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0},
    '{32'h1234_5678, 32'h0000_FFFF, 32'h1233_5679, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0}
  };

  vec_t bp_v[4] = '{
    '{32'h0000_0064, 32'h0000_0001, 32'h0000_0063, 1'b0, 1'b0},
    '{32'h0002_0000, 32'h0000_0001, 32'h0001_FFFF, 1'b0, 1'b0},
    '{32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1}
  };

  initial begin
    RST = 1'b1;
    A = '0;
    B = '0;
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    lat_chk = 1'b1;

    // Reset state
    #12;
    check("reset_out_valid", 64'(Out_Valid), 64'd0);
    check("reset_d", 64'(D), 64'd0);
    check("reset_bout", 64'(Bout), 64'd0);
    check("reset_in_ready", 64'(In_Ready), 64'd1);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post_reset_in_ready", 64'(In_Ready), 64'd1);
    @(posedge CLK);
    #1;

    // Directed vectors, back to back, no backpressure
    foreach (dir_v[i]) drive(dir_v[i].a, dir_v[i].b, dir_v[i].d, dir_v[i].bo, dir_v[i].ov);
    drain();

    // Backpressure
    lat_chk = 1'b0;
    Out_Ready = 1'b0;
    drive(bp_v[0].a, bp_v[0].b, bp_v[0].d, bp_v[0].bo, bp_v[0].ov);
    drive(bp_v[1].a, bp_v[1].b, bp_v[1].d, bp_v[1].bo, bp_v[1].ov);
    @(negedge CLK);
    check("bp_in_ready_low", 64'(In_Ready), 64'd0);
    fork
      begin
        drive(bp_v[2].a, bp_v[2].b, bp_v[2].d, bp_v[2].bo, bp_v[2].ov);
        drive(bp_v[3].a, bp_v[3].b, bp_v[3].d, bp_v[3].bo, bp_v[3].ov);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          check("bp_hold_valid", 64'(Out_Valid), 64'd1);
          check("bp_hold_d", 64'(D), 64'h63);
          check("bp_hold_in_ready", 64'(In_Ready), 64'd0);
        end
        @(posedge CLK);
        #1;
        Out_Ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full
    Out_Ready = 1'b0;
    drive(32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0);
    drive(32'h0000_0008, 32'h0000_0002, 32'h0000_0006, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("midreset_out_valid", 64'(Out_Valid), 64'd0);
    check("midreset_d", 64'(D), 64'd0);
    check("midreset_in_ready", 64'(In_Ready), 64'd1);
    exp_q.delete();
    cyc_q.delete();
    chk_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    Out_Ready = 1'b1;
    lat_chk = 1'b1;
    @(negedge CLK);
    check("after_reset_in_ready", 64'(In_Ready), 64'd1);
    check("after_reset_out_valid", 64'(Out_Valid), 64'd0);
    @(posedge CLK);
    #1;
    drive(32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0);
    drain();

    // Back-to-back random stream; per-entry latency of 2 means no bubbles
    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra, rb, rd;
      ra = $urandom_range(32'hFFFF_FFFF, 0);
      rb = (i % 4 == 0) ? {ra[31:16], 16'($urandom_range(16'hFFFF, 0))} : $urandom_range(32'hFFFF_FFFF, 0);
      rd = ra - rb;
      drive(ra, rb, rd, (ra < rb), (ra[31] != rb[31]) && (rd[31] != ra[31]));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_sub.md
PIPE_SUB -- requirements
Module: pipe_sub

Interface
REQ-001 SHALL have parameter SPLIT, default 16: bit position at which the pipeline splits the 32-bit difference (legal range 1..31).
REQ-002 SHALL have port CLK, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port A, input, 32: minuend.
REQ-005 SHALL have port B, input, 32: subtrahend.
REQ-006 SHALL have port In_Valid, input, 1: A/B are valid this cycle.
REQ-007 SHALL have port In_Ready, output, 1: block accepts A/B this cycle.
REQ-008 SHALL have port D, output, 32: registered difference A-B mod 2^32.
REQ-009 SHALL have port Bout, output, 1: borrow out; 1 iff A<B unsigned.
REQ-010 SHALL have port Out_Valid, output, 1: D/Bout are valid.
REQ-011 SHALL have port Out_Ready, input, 1: consumer accepts D/Bout.

Function
REQ-012 SHALL transfer on input when In_Valid and In_Ready are both 1, and on output when Out_Valid and Out_Ready are both 1.
REQ-013 SHALL compute D = A + ~B + 1 and Bout = ~carry-out of that sum.
REQ-014 SHALL have two stages. S1 registers the low difference [SPLIT-1:0], the low borrow, and both candidate high differences [31:SPLIT] for borrow-in 0 and 1. S2 selects the high candidate with the S1 low borrow and registers D and Bout.
REQ-015 SHALL have a latency of exactly 2 cycles from input transfer to Out_Valid when there is no backpressure.
REQ-016 SHALL sustain a throughput of one transfer per cycle while Out_Ready is held at 1.
REQ-017 SHALL advance S2 (s2_en) when S1 is valid and either S2 is empty or Out_Ready is 1.
REQ-018 SHALL set In_Ready = ~s1_valid | s2_en; this is combinational and does not depend on In_Valid.
REQ-019 SHALL hold D, Bout and Out_Valid stable while Out_Valid=1 and Out_Ready=0.
REQ-020 SHALL, when an input transfer and an S1→S2 move occur in the same cycle, load S1 with the new operands and keep s1_valid at 1.
REQ-021 SHALL, when an output transfer occurs with no S1→S2 move, clear Out_Valid on the next edge.
REQ-022 SHALL never drop or duplicate a transaction; its capacity is 2 transactions.
REQ-023 SHALL hold data registers of invalid stages at their last value; D is don't-care while Out_Valid=0.

Reset
REQ-024 SHALL, on RST assertion, immediately clear s1_valid and Out_Valid and set D=0 and Bout=0, independent of CLK.
REQ-025 SHALL discard all in-flight transactions when RST is asserted mid-operation.
REQ-026 SHALL hold In_Ready=1 during reset and in the first cycle after RST deasserts.

Configuration
REQ-027 SHALL, with macro PIPE_SUB_OVF_EN defined, add output Ovf (1 bit), registered alongside D, reset to 0: signed overflow = (A[31]≠B[31]) & (D[31]≠A[31]).
REQ-028 SHALL, without PIPE_SUB_OVF_EN, omit the Ovf port and its logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL take the data width constant (32) and a stage-register struct type (data, borrow, valid) from shared package arith_pkg, which is reused by the adder blocks.
REQ-030 SHALL implement each width-parameterised half-difference (ripple subtract with borrow-in and borrow-out) in one sub-module, sub_slice, instantiated three times: low half, high half with borrow 0, high half with borrow 1.

Verification
REQ-031 SHALL cover: A=0x0000_000A, B=0x0000_0003, Out_Ready=1 → D=0x0000_0007, Bout=0, Out_Valid exactly 2 cycles after transfer.
REQ-032 SHALL cover borrow across the split: A=0x0001_0000, B=0x0000_0001 → D=0x0000_FFFF, Bout=0.
REQ-033 SHALL cover wrap-around: A=0, B=1 → D=0xFFFF_FFFF, Bout=1; with PIPE_SUB_OVF_EN, A=0x8000_0000, B=1 → Ovf=1.
REQ-034 SHALL cover backpressure: stream 4 operand pairs with Out_Ready=0 → In_Ready falls after 2 accepts, D holds the first result; release Out_Ready → all 4 results appear in order, none lost.
REQ-035 SHALL cover reset mid-flight: assert RST while both stages are valid → Out_Valid=0 and D=0 before the next CLK edge; after release, the first new pair yields its correct result.
REQ-036 SHALL cover back-to-back throughput: 100 random pairs, In_Valid and Out_Ready held at 1 → 100 consecutive valid outputs matching the reference A-B, with no bubble cycles.
